noc_out_rr_sched: RTL and testbench
===================================

# noc_out_rr_sched

Per-output-port scheduler for the hypercube router crossbar. It arbitrates between the five input channels that request the same output port, and locks the grant to one input for a whole packet (head through tail flit). It uses round-robin priority across packets and gates flit forwarding with a credit counter that tracks free slots in the downstream input buffer. It sits between the input channel controllers and the output channel mux, and drives the mux select directly.

## Interface
- PORTID, 0, index of the output port this scheduler owns
- NPORT, 5, number of requesting input channels
- PW, 3, width of each destination-port field
- CREDITS, 4, downstream buffer depth; credit counter reset value
- CW, 3, credit counter width; must hold CREDITS
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NPORT  head-of-line flit valid per input channel
- dest  input  NPORT*PW  destination port of each head-of-line flit; slice i is bits [i*PW +: PW]
- tail  input  NPORT  head-of-line flit of input i is a tail flit (single-flit packet: head and tail both set)
- credit_in  input  1  one-cycle pulse; downstream freed one buffer slot
- grt  output  NPORT  registered one-hot grant to the owning input; flit consumed when grt[i] & fwd
- sel  output  NPORT  output mux select; equals grt
- fwd  output  1  combinational; a flit crosses the output this cycle
- credit_cnt  output  CW  current credits available
- busy  output  1  registered; scheduler is in LOCKED
- credit_err  output  1  sticky; credit_in received while credit_cnt == CREDITS

## Operation
- Request match: m[i] = req[i] & (dest slice i == PORTID).
- State IDLE:
  - If any m[i] is set, pick the first set index searching ptr+1, ptr+2, … modulo NPORT.
  - Register the pick as a one-hot grt, set owner, and go to LOCKED.
  - Otherwise stay in IDLE with grt = 0.
  - Credit availability does not block grant.
- State LOCKED:
  - fwd = req[owner] & (credit_cnt != 0).
  - On fwd & tail[owner]: clear grt, set ptr <= owner, go to IDLE.
  - Otherwise hold the grant. If the owner drops req mid-packet, the scheduler stays locked and stalls; it never preempts.
- Credits:
  - fwd alone: credit_cnt -1.
  - credit_in alone: credit_cnt +1, saturating at CREDITS; a pulse at CREDITS sets credit_err and the count is unchanged.
  - fwd and credit_in in the same cycle: count unchanged.
- dest is ignored in LOCKED. Body flits are routed by the lock, not by dest.

## Timing
- Reset values: grt=0, sel=0, fwd=0, busy=0, credit_cnt=CREDITS, credit_err=0, ptr=NPORT-1 (input 0 has first priority), state IDLE.
- Grant latency: a request matching in cycle N gives grt/sel/busy high from cycle N+1. The first flit can forward in N+1.
- Throughput is one flit per cycle while the owner holds req and credits are nonzero.
- Tail forwarded in cycle T: grt=0 and busy=0 in T+1; a new grant appears in T+2. Minimum gap between packets is one idle cycle.
- A credit_in pulse in cycle N is reflected in credit_cnt at N+1 and can enable fwd in N+1.
- Reset asserted mid-packet clears all state immediately; the partial packet is the upstream's responsibility.

## Configuration
- CREDIT_FC_EN defined:
  - Credit counter active as described.
  - fwd is gated by credit_cnt != 0.
  - credit_err is functional.
- CREDIT_FC_EN undefined:
  - credit_in is ignored.
  - credit_cnt is tied to CREDITS and credit_err is tied to 0.
  - fwd = busy & req[owner].

## Test plan
- Single input: req[2]=1, dest2=PORTID, 3-flit packet with tail on flit 3 -> grt=00100 from cycle 1; fwd on cycles 1–3; busy low at cycle 4; credit_cnt 4→1.
- Contention: inputs 0, 1, 3 all request PORTID, one-flit packets, held continuously -> grant order 0, 1, 3, 0 with one idle cycle between grants.
- Wrong destination: req[4]=1 with dest4 != PORTID -> grt stays 0 and busy stays 0 indefinitely.
- Credit stall: CREDITS=4, 6-flit packet, no credit_in -> 4 flits forwarded, fwd=0 while grant is held; a credit_in pulse gives exactly one more fwd the next cycle; a simultaneous fwd and credit_in leaves the count unchanged.
- Overflow and reset: credit_in at credit_cnt=4 -> credit_err=1 and sticky. Assert reset mid-packet -> grt=0, busy=0, credit_cnt=4, credit_err=0 without waiting for a clock edge.

Source files
------------

// File: rtl/noc_out_rr_sched.sv
// Per-output-port round-robin packet scheduler with downstream credit gating.
// Optional feature macro: CREDIT_FC_EN (credit flow control; undefined = credits ignored).
module noc_out_rr_sched #(
  parameter int PORTID  = 0,
  parameter int NPORT   = 5,
  parameter int PW      = 3,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT*PW-1:0] dest,
  input  logic [NPORT-1:0]    tail,
  input  logic                credit_in,
  output logic [NPORT-1:0]    grt,
  output logic [NPORT-1:0]    sel,
  output logic                fwd,
  output logic [CW-1:0]       credit_cnt,
  output logic                busy,
  output logic                credit_err
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [NPORT-1:0] grt_q, grt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NPORT-1:0] match;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             fwd_w;
  int unsigned      idx;

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      match[i] = req[i] & (dest[i*PW +: PW] == PW'(PORTID));
    end
  end

  // Search starts one past the last owner so the previous winner has lowest priority.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NPORT; k++) begin
      idx = (int'(ptr_q) + k) % NPORT;
      if (!pick_vld && match[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grt_d   = '0;
          grt_d[pick] = 1'b1;
          owner_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (fwd_w && tail[owner_q]) begin
          grt_d   = '0;
          ptr_d   = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(NPORT - 1);
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef CREDIT_FC_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign fwd_w = (state_q == LOCKED) & req[owner_q] & (cnt_q != '0);

  // A return and a consume in the same cycle cancel, even at full count.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({fwd_w, credit_in})
      2'b10: cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == CW'(CREDITS)) err_d = 1'b1;
        else                       cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CW'(CREDITS);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credit_cnt = cnt_q;
  assign credit_err = err_q;
`else
  logic unused_credit_in;
  assign unused_credit_in = credit_in;
  assign fwd_w      = (state_q == LOCKED) & req[owner_q];
  assign credit_cnt = CW'(CREDITS);
  assign credit_err = 1'b0;
`endif

  assign fwd  = fwd_w;
  assign grt  = grt_q;
  assign sel  = grt_q;
  assign busy = (state_q == LOCKED);

endmodule

// File: tb/tb_noc_out_rr_sched.sv
// Bench for noc_out_rr_sched: directed scenarios plus randomized traffic against a packet-level model.
module tb_noc_out_rr_sched;
  localparam int PORTID  = 0;
  localparam int NPORT   = 5;
  localparam int PW      = 3;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
`ifdef CREDIT_FC_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NPORT-1:0]    req;
  logic [NPORT*PW-1:0] dest;
  logic [NPORT-1:0]    tail;
  logic                credit_in;
  logic [NPORT-1:0]    grt;
  logic [NPORT-1:0]    sel;
  logic                fwd;
  logic [CW-1:0]       credit_cnt;
  logic                busy;
  logic                credit_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  noc_out_rr_sched #(
    .PORTID(PORTID), .NPORT(NPORT), .PW(PW), .CREDITS(CREDITS), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .dest(dest), .tail(tail),
    .credit_in(credit_in), .grt(grt), .sel(sel), .fwd(fwd),
    .credit_cnt(credit_cnt), .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic set_dest(input int i, input int v);
    dest[i*PW +: PW] = PW'(v);
  endtask

  function automatic logic [NPORT-1:0] exp_grt();
    logic [NPORT-1:0] g;
    g = '0;
    if (m_locked) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_fwd();
    if (!m_locked) return 1'b0;
    return req[m_owner] && (!FC || m_cred != 0);
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = NPORT - 1;
    m_cred   = CREDITS;
    m_err    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clock();
    bit f;
    int cand;
    f = exp_fwd();
    if (FC) begin
      if (f && !credit_in) m_cred = m_cred - 1;
      else if (!f && credit_in) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
    end
    if (!m_locked) begin
      for (int k = 1; k <= NPORT; k++) begin
        cand = (m_ptr + k) % NPORT;
        if (!m_locked && req[cand] && dest[cand*PW +: PW] == PW'(PORTID)) begin
          m_locked = 1'b1;
          m_owner  = cand;
        end
      end
    end else if (f && tail[m_owner]) begin
      m_locked = 1'b0;
      m_ptr    = m_owner;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    req       = '0;
    tail      = '0;
    dest      = '0;
    credit_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    total++; if (grt !== '0) begin bad++; $display("FAIL reset_grt got=%b exp=0", grt); end
    total++; if (sel !== '0) begin bad++; $display("FAIL reset_sel got=%b exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (fwd !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0", fwd); end
    total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL reset_cnt got=%0d exp=%0d", credit_cnt, CREDITS); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", credit_err); end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single();
    idle_inputs();
    for (int c = 0; c <= 4; c++) begin
      req  = (c <= 3) ? 5'b00100 : 5'b00000;
      tail = (c == 3) ? 5'b00100 : 5'b00000;
      #1;
      total++; if (grt !== exp_grt()) begin bad++; $display("FAIL single_grt c=%0d got=%b exp=%b", c, grt, exp_grt()); end
      total++; if (fwd !== exp_fwd()) begin bad++; $display("FAIL single_fwd c=%0d got=%b exp=%b", c, fwd, exp_fwd()); end
      if (c >= 1 && c <= 3) begin
        total++; if (grt !== 5'b00100 || fwd !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL single_flit c=%0d got grt=%b fwd=%b busy=%b exp grt=00100 fwd=1 busy=1", c, grt, fwd, busy);
        end
      end
      if (c == 4) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done busy=%b exp=0", busy); end
        total++; if (credit_cnt !== CW'(FC ? 1 : CREDITS)) begin
          bad++; $display("FAIL single_cnt got=%0d exp=%0d", credit_cnt, FC ? 1 : CREDITS);
        end
      end
      tick();
    end
    credit_in = 1'b1;
    repeat (3) tick();
    credit_in = 1'b0;
    #1;
    total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL single_refill got=%0d exp=%0d", credit_cnt, CREDITS); end
  endtask

  task automatic test_contention();
    logic [NPORT-1:0] exp_seq [8];
    exp_seq = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b01000, 5'b00000, 5'b00001};
    idle_inputs();
    pulse_reset();
    req  = 5'b01011;
    tail = 5'b11111;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (grt !== exp_seq[c]) begin bad++; $display("FAIL contend_order c=%0d got=%b exp=%b", c, grt, exp_seq[c]); end
      total++; if (fwd !== exp_fwd()) begin bad++; $display("FAIL contend_fwd c=%0d got=%b exp=%b", c, fwd, exp_fwd()); end
      tick();
    end
  endtask

  task automatic test_wrong_dest();
    idle_inputs();
    pulse_reset();
    req = 5'b10000;
    set_dest(4, 3);
    for (int c = 0; c < 20; c++) begin
      #1;
      total++; if (grt !== '0 || busy !== 1'b0 || fwd !== 1'b0) begin
        bad++; $display("FAIL wrongdest c=%0d got grt=%b busy=%b fwd=%b exp all 0", c, grt, busy, fwd);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_credit_stall();
    int early_flits;
    int exp_f   [10] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0};
    int exp_cnt [10] = '{4, 4, 3, 2, 1, 0, 0, 1, 1, 0};
    early_flits = 0;
    idle_inputs();
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      req       = (c <= 8) ? 5'b00010 : 5'b00000;
      tail      = (c == 8) ? 5'b00010 : 5'b00000;
      credit_in = (c == 6 || c == 7);
      #1;
      if (c <= 6 && fwd === 1'b1) early_flits++;
      total++; if (fwd !== exp_fwd()) begin bad++; $display("FAIL stall_fwd c=%0d got=%b exp=%b", c, fwd, exp_fwd()); end
      total++; if (credit_cnt !== CW'(m_cred)) begin bad++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, credit_cnt, m_cred); end
`ifdef CREDIT_FC_EN
      total++; if (fwd !== 1'(exp_f[c]) || credit_cnt !== CW'(exp_cnt[c])) begin
        bad++; $display("FAIL stall_plan c=%0d got fwd=%b cnt=%0d exp fwd=%0d cnt=%0d", c, fwd, credit_cnt, exp_f[c], exp_cnt[c]);
      end
      if (c == 5 || c == 6) begin
        total++; if (grt !== 5'b00010 || busy !== 1'b1) begin
          bad++; $display("FAIL stall_hold c=%0d got grt=%b busy=%b exp grt=00010 busy=1", c, grt, busy);
        end
      end
`endif
      tick();
    end
    credit_in = 1'b0;
    total++; if (early_flits != (FC ? 4 : 6)) begin bad++; $display("FAIL stall_flits got=%0d exp=%0d", early_flits, FC ? 4 : 6); end
    idle_inputs();
  endtask

  task automatic test_overflow_reset();
    idle_inputs();
    pulse_reset();
    credit_in = 1'b1;
    #1;
    tick();
    credit_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (credit_err !== FC) begin bad++; $display("FAIL ovf_err c=%0d got=%b exp=%b", c, credit_err, FC); end
      total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL ovf_cnt c=%0d got=%0d exp=%0d", c, credit_cnt, CREDITS); end
      tick();
    end
    req = 5'b00001;
    #1;
    tick();
    tick();
    total++; if (busy !== 1'b1 || grt !== 5'b00001) begin bad++; $display("FAIL ovf_lock got grt=%b busy=%b exp grt=00001 busy=1", grt, busy); end
    reset = 1'b1;
    #1;
    total++; if (grt !== '0 || sel !== '0 || busy !== 1'b0 || fwd !== 1'b0) begin
      bad++; $display("FAIL midreset_ctl got grt=%b sel=%b busy=%b fwd=%b exp all 0", grt, sel, busy, fwd);
    end
    total++; if (credit_cnt !== CW'(CREDITS) || credit_err !== 1'b0) begin
      bad++; $display("FAIL midreset_cred got cnt=%0d err=%b exp cnt=%0d err=0", credit_cnt, credit_err, CREDITS);
    end
    reset = 1'b0;
    model_reset();
    idle_inputs();
  endtask

  task automatic test_random();
    idle_inputs();
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) pulse_reset();
      req  = NPORT'($urandom);
      tail = NPORT'($urandom) & NPORT'($urandom);
      for (int i = 0; i < NPORT; i++) begin
        set_dest(i, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : PORTID);
      end
      credit_in = ($urandom_range(0, 2) == 0);
      #1;
      total++; if (grt !== exp_grt() || sel !== exp_grt()) begin
        bad++; $display("FAIL rand_grt c=%0d got grt=%b sel=%b exp=%b", c, grt, sel, exp_grt());
      end
      total++; if (fwd !== exp_fwd()) begin bad++; $display("FAIL rand_fwd c=%0d got=%b exp=%b", c, fwd, exp_fwd()); end
      total++; if (busy !== m_locked) begin bad++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_locked); end
      total++; if (credit_cnt !== CW'(m_cred) || credit_err !== m_err) begin
        bad++; $display("FAIL rand_cred c=%0d got cnt=%0d err=%b exp cnt=%0d err=%b", c, credit_cnt, credit_err, m_cred, m_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrong_dest();
    test_credit_stall();
    test_overflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
